// File: rtl/rr_slot_arbiter.sv
// ---------------------------------------------------------------------------
// rr_slot_arbiter
//
// Purpose:
//   This module issues the grants for the 8-channel fixed-slot timing scheme.
//   It arbitrates channel requests round-robin and owns the slot timer.
//   A slot is SLOT_LEN cycles long:
//     - SLOT_LEN-1 grant cycles, during which gnt is one-hot and gnt_done=1.
//     - One guard cycle, during which gnt=0 and slot_done=1.
//   At the end of the guard cycle the arbiter either starts the next slot
//   back-to-back or returns to idle.
//   Every output is registered, so no combinational path runs from req/rel
//   to any output.
//
// Optional feature (compile-time macro SLOT_PRIO_CH0_EN):
//   defined   : ch0 wins any arbitration in which req[0]=1. A ch0 grant leaves
//               the rotation pointer untouched, so ch1..NCH-1 keep their order.
//   undefined : pure round-robin over all NCH channels.
//
// Ports:
//   Clk          in   1     clock, rising edge
//   count_reset  in   1     asynchronous, active-high reset
//   req          in   NCH   per-channel request level
//   rel          in   NCH   per-channel early release (granted channel only)
//   gnt          out  NCH   one-hot grant
//   gnt_id       out  IDW   index of current/last granted channel
//   gnt_done     out  1     grant window open
//   slot_done    out  1     one-cycle pulse on the guard cycle
//   busy         out  1     arbiter is inside a slot (GRANT state)
// ---------------------------------------------------------------------------
module rr_slot_arbiter #(
    parameter int NCH      = 8,
    parameter int SLOT_LEN = 10,
    parameter int CW       = 4,
    parameter int IDW      = 3
) (
    input  logic           Clk,
    input  logic           count_reset,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] rel,
    output logic [NCH-1:0] gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_done,
    output logic           slot_done,
    output logic           busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    // Counter value of the guard cycle, and of the last grant cycle.
    localparam logic [CW-1:0] CNT_GUARD = CW'(SLOT_LEN - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_LEN - 2);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           gnt_done_q, gnt_done_d;
    logic           slot_done_q, slot_done_d;
    logic           busy_q, busy_d;

    logic [IDW-1:0] winner;
    logic           upd_ptr;
    logic           start_slot;

    // Returns the first requesting channel after p, scanning p+1, p+2, ...
    // modulo NCH. p itself is checked last, so a channel that was just served
    // waits behind every other requester.
    function automatic logic [IDW-1:0] rr_pick(input logic [NCH-1:0] r,
                                               input logic [IDW-1:0] p);
        logic [IDW-1:0] w;
        logic           found;
        int             idx;
        w     = '0;
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(p) + i) % NCH;
            if (!found && r[IDW'(idx)]) begin
                w     = IDW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_ff @(posedge Clk or posedge count_reset) begin
        if (count_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= IDW'(NCH - 1);
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_done_q  <= 1'b0;
            slot_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_done_q  <= gnt_done_d;
            slot_done_q <= slot_done_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_done_d  = gnt_done_q;
        slot_done_d = slot_done_q;
        busy_d      = busy_q;
        start_slot  = 1'b0;

        winner  = rr_pick(req, ptr_q);
        upd_ptr = 1'b1;
`ifdef SLOT_PRIO_CH0_EN
        // ch0 overrides the rotation and does not move the pointer.
        if (req[0]) begin
            winner  = '0;
            upd_ptr = 1'b0;
        end
`endif

        case (state_q)
            IDLE: begin
                cnt_d       = '0;
                slot_done_d = 1'b0;
                if (|req) begin
                    start_slot = 1'b1;
                end
            end
            GRANT: begin
                if (cnt_q == CNT_GUARD) begin
                    // End of guard: chain straight into the next slot or go idle.
                    slot_done_d = 1'b0;
                    cnt_d       = '0;
                    if (|req) begin
                        start_slot = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else if ((cnt_q == CNT_LAST) || ((rel & gnt_q) != '0)) begin
                    // Timeout, or early release by the owner: jump to the guard cycle.
                    // gnt_q is one-hot on the owner here, so masking ignores other rel bits.
                    cnt_d       = CNT_GUARD;
                    gnt_d       = '0;
                    gnt_done_d  = 1'b0;
                    slot_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_slot) begin
            state_d    = GRANT;
            cnt_d      = '0;
            gnt_d      = {{(NCH-1){1'b0}}, 1'b1} << winner;
            gnt_id_d   = winner;
            gnt_done_d = 1'b1;
            busy_d     = 1'b1;
            if (upd_ptr) begin
                ptr_d = winner;
            end
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_done  = gnt_done_q;
    assign slot_done = slot_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rr_slot_arbiter.sv
module tb_rr_slot_arbiter;

    localparam int NCH      = 8;
    localparam int SLOT_LEN = 10;
    localparam int IDW      = 3;
`ifdef SLOT_PRIO_CH0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic           Clk = 1'b0;
    logic           count_reset = 1'b1;
    logic [NCH-1:0] req = '0;
    logic [NCH-1:0] rel = '0;
    logic [NCH-1:0] gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_done;
    logic           slot_done;
    logic           busy;

    int checks = 0;
    int errors = 0;

    rr_slot_arbiter dut (
        .Clk        (Clk),
        .count_reset(count_reset),
        .req        (req),
        .rel        (rel),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .gnt_done   (gnt_done),
        .slot_done  (slot_done),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A slot is described by its owner and how many grant cycles have been shown;
    // the guard flag marks the single cycle between slots.
    bit m_active = 1'b0;
    bit m_guard  = 1'b0;
    int m_shown  = 0;
    int m_owner  = 0;
    int m_id     = 0;
    int m_ptr    = NCH - 1;

    function automatic int pick(input logic [NCH-1:0] r, input int p);
        if (PRIO && r[0]) return 0;
        for (int i = 1; i <= NCH; i++) begin
            if (r[(p + i) % NCH]) return (p + i) % NCH;
        end
        return 0;
    endfunction

    always @(posedge Clk or posedge count_reset) begin
        if (count_reset) begin
            m_active <= 1'b0;
            m_guard  <= 1'b0;
            m_shown  <= 0;
            m_owner  <= 0;
            m_id     <= 0;
            m_ptr    <= NCH - 1;
        end else if (!m_active || m_guard) begin
            if (req != '0) begin
                m_owner  <= pick(req, m_ptr);
                m_id     <= pick(req, m_ptr);
                if (!(PRIO && req[0])) m_ptr <= pick(req, m_ptr);
                m_active <= 1'b1;
                m_guard  <= 1'b0;
                m_shown  <= 1;
            end else begin
                m_active <= 1'b0;
                m_guard  <= 1'b0;
            end
        end else if (m_shown == SLOT_LEN - 1 || rel[m_owner]) begin
            m_guard <= 1'b1;
        end else begin
            m_shown <= m_shown + 1;
        end
    end

    always @(negedge Clk) begin
        if (!count_reset) begin
            chk("cmp_gnt", 32'(gnt), (m_active && !m_guard) ? (32'd1 << m_owner) : 32'd0);
            chk("cmp_gnt_id", 32'(gnt_id), 32'(m_id));
            chk("cmp_gnt_done", 32'(gnt_done), 32'(m_active && !m_guard));
            chk("cmp_slot_done", 32'(slot_done), 32'(m_guard));
            chk("cmp_busy", 32'(busy), 32'(m_active));
        end
    end

    // ---------------- directed stimulus ----------------
    int          gq[$];
    logic [NCH-1:0] prevg;

    task automatic do_reset();
        @(negedge Clk);
        count_reset = 1'b1;
        req = '0;
        rel = '0;
        repeat (2) @(negedge Clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_gnt_done", 32'(gnt_done), 32'd0);
        chk("rst_slot_done", 32'(slot_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        count_reset = 1'b0;
    endtask

    task automatic collect(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            if (gnt != '0 && prevg == '0) gq.push_back(int'(gnt_id));
            prevg = gnt;
            @(negedge Clk);
        end
    endtask

    initial begin
        int nd, sd, ng, ns;
        int exp5[4];

        // Test 1: single request on ch2, full slot then idle.
        do_reset();
        req = 8'h04;
        @(negedge Clk);
        chk("t1_gnt", 32'(gnt), 32'h04);
        req = '0;
        nd = 0; sd = 0;
        for (int k = 1; k <= 12; k++) begin
            if (gnt_done) nd++;
            if (slot_done) sd = k;
            @(negedge Clk);
        end
        chk("t1_gnt_done_cycles", 32'(nd), 32'd9);
        chk("t1_slot_done_cycle", 32'(sd), 32'd10);
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // Test 2: all requesting, strict rotation.
        do_reset();
        gq.delete(); prevg = '0;
        req = 8'hFF;
        @(negedge Clk);
        collect(85);
        chk("t2_grant_count", 32'(gq.size() >= 9), 32'd1);
        for (int i = 0; i < 9 && i < gq.size(); i++)
            chk("t2_order", 32'(gq[i]), PRIO ? 32'd0 : 32'(i % NCH));
        req = '0;
        repeat (12) @(negedge Clk);

        // Test 3: early release by ch3, foreign rel bit ignored.
        do_reset();
        req = 8'h08;
        @(negedge Clk);
        req = '0;
        @(negedge Clk);
        rel = 8'h18;
        @(negedge Clk);
        rel = '0;
        chk("t3_guard_gnt", 32'(gnt), 32'd0);
        chk("t3_guard_slot_done", 32'(slot_done), 32'd1);
        chk("t3_guard_gnt_done", 32'(gnt_done), 32'd0);
        @(negedge Clk);
        chk("t3_idle_busy", 32'(busy), 32'd0);
        req = 8'h08;
        @(negedge Clk);
        req = '0;
        rel = 8'h10;
        @(negedge Clk);
        rel = '0;
        chk("t3_other_rel_ignored", 32'(gnt), 32'h08);
        repeat (12) @(negedge Clk);

        // Test 4: reset mid-slot, then ch0 wins the first arbitration.
        do_reset();
        req = 8'h08;
        @(negedge Clk);
        req = '0;
        repeat (5) @(negedge Clk);
        count_reset = 1'b1;
        #1;
        chk("t4_async_gnt", 32'(gnt), 32'd0);
        chk("t4_async_busy", 32'(busy), 32'd0);
        chk("t4_async_gnt_done", 32'(gnt_done), 32'd0);
        req = 8'h81;
        @(negedge Clk);
        count_reset = 1'b0;
        @(negedge Clk);
        chk("t4_gnt_ch0", 32'(gnt), 32'h01);
        chk("t4_gnt_id", 32'(gnt_id), 32'd0);
        req = '0;
        repeat (12) @(negedge Clk);

        // Test 5: ch0 and ch1 requesting, then ch0 drops.
        do_reset();
        gq.delete(); prevg = '0;
        req = 8'h03;
        @(negedge Clk);
        collect(25);
        req = 8'h02;
        collect(15);
        if (PRIO) exp5 = '{0, 0, 0, 1};
        else      exp5 = '{0, 1, 0, 1};
        chk("t5_grant_count", 32'(gq.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            chk("t5_order", 32'(gq[i]), 32'(exp5[i]));
        req = '0;
        repeat (12) @(negedge Clk);

        // Test 6: one-cycle request pulse still earns a full slot.
        do_reset();
        req = 8'h20;
        @(negedge Clk);
        req = '0;
        ng = 0; ns = 0;
        for (int k = 1; k <= 12; k++) begin
            if (gnt == 8'h20) ng++;
            if (slot_done) ns++;
            @(negedge Clk);
        end
        chk("t6_grant_cycles", 32'(ng), 32'd9);
        chk("t6_slot_done_pulses", 32'(ns), 32'd1);
        chk("t6_busy_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
